vector_execute_stage: RTL and testbench

VECTOR_EXECUTE_STAGE -- requirements
Module: vector_execute_stage

---
 rtl/vector_execute_stage.sv | 135 +++++++++++++
 tb/tb_vector_execute_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_execute_stage.sv
// Vector execute stage: 16-lane ALU with a 4-edge pipelined lane reduction.
// Ports: clk/rst (async, active-high); valid_in/ready accept handshake;
//   cmd, selec_v_s, dest, srca, srcb in; we3, ra3, wd3, selec_v_s_w, cmd_w
//   out to the register-file write port, valid for one cycle per op.
module vector_execute_stage #(
    parameter int LANES = 16,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_in,
    output logic                       ready,
    input  logic [2:0]                 cmd,
    input  logic                       selec_v_s,
    input  logic [3:0]                 dest,
    input  logic [LANES-1:0][DW-1:0]   srca,
    input  logic [LANES-1:0][DW-1:0]   srcb,
    output logic                       we3,
    output logic [3:0]                 ra3,
    output logic [LANES-1:0][DW-1:0]   wd3,
    output logic                       selec_v_s_w,
    output logic [2:0]                 cmd_w
);

    localparam logic [2:0] OP_RED = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        R8,
        R4,
        R2
    } state_t;

    state_t state;

    logic [7:0][DW-1:0]       p8;
    logic [3:0][DW-1:0]       p4;
    logic [1:0][DW-1:0]       p2;
    logic [LANES-1:0][DW-1:0] alu;
    logic [LANES-1:0][DW-1:0] red_out;
    logic                     accept;
    logic                     red_vec;

    function automatic logic [DW-1:0] lane_op(
        input logic [2:0]    op,
        input logic [DW-1:0] a,
        input logic [DW-1:0] b
    );
        logic [DW-1:0] r;
        case (op)
            3'b000:  r = a + b;
            3'b001:  r = a - b;
            3'b010:  r = a & b;
            3'b011:  r = a | b;
            3'b100:  r = a ^ b;
            3'b110:  r = a * b;
            3'b111:  r = b;
            // scalar reduction of a single lane is the lane itself
            default: r = a;
        endcase
        return r;
    endfunction

    assign ready   = (state == IDLE);
    assign accept  = valid_in && ready;
    assign red_vec = (cmd == OP_RED) && selec_v_s;

    // Scalar mode only computes the top lane; the rest read back as zero.
    always_comb begin
        alu = '0;
        for (int i = 0; i < LANES; i++) begin
            if (selec_v_s || i == LANES - 1) begin
                alu[i] = lane_op(cmd, srca[i], srcb[i]);
            end
        end
    end

    always_comb begin
        red_out            = '0;
        red_out[LANES-1]   = p2[0] + p2[1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            we3         <= 1'b0;
            ra3         <= '0;
            wd3         <= '0;
            selec_v_s_w <= 1'b0;
            cmd_w       <= '0;
            p8          <= '0;
            p4          <= '0;
            p2          <= '0;
        end else begin
            we3 <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        ra3         <= dest;
                        cmd_w       <= cmd;
                        selec_v_s_w <= selec_v_s;
                        if (red_vec) begin
                            for (int i = 0; i < 8; i++) begin
                                p8[i] <= srca[2*i] + srca[2*i+1];
                            end
                            state <= R8;
                        end else begin
                            wd3 <= alu;
                            we3 <= 1'b1;
                        end
                    end
                end
                R8: begin
                    for (int i = 0; i < 4; i++) begin
                        p4[i] <= p8[2*i] + p8[2*i+1];
                    end
                    state <= R4;
                end
                R4: begin
                    for (int i = 0; i < 2; i++) begin
                        p2[i] <= p4[2*i] + p4[2*i+1];
                    end
                    state <= R2;
                end
                R2: begin
                    wd3   <= red_out;
                    we3   <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_execute_stage.sv
// Directed bench for vector_execute_stage: ALU ops, scalar masking,
// pipelined reduction timing, reset abort and handshake back-pressure.
module tb_vector_execute_stage;

    localparam int L = 16;
    localparam int W = 32;

    typedef logic [L-1:0][W-1:0] vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_in;
    logic       ready;
    logic [2:0] cmd;
    logic       selec_v_s;
    logic [3:0] dest;
    vec_t       srca;
    vec_t       srcb;
    logic       we3;
    logic [3:0] ra3;
    vec_t       wd3;
    logic       selec_v_s_w;
    logic [2:0] cmd_w;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    vector_execute_stage #(.LANES(L), .DW(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .ready       (ready),
        .cmd         (cmd),
        .selec_v_s   (selec_v_s),
        .dest        (dest),
        .srca        (srca),
        .srcb        (srcb),
        .we3         (we3),
        .ra3         (ra3),
        .wd3         (wd3),
        .selec_v_s_w (selec_v_s_w),
        .cmd_w       (cmd_w)
    );

    task automatic chk(
        input string        tag,
        input logic [511:0] got,
        input logic [511:0] exp
    );
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic vec_t splat(input logic [W-1:0] v);
        vec_t r;
        for (int i = 0; i < L; i++) r[i] = v;
        return r;
    endfunction

    function automatic vec_t top(input logic [W-1:0] v);
        vec_t r;
        r     = '0;
        r[15] = v;
        return r;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic op(
        input logic [2:0] c,
        input logic       s,
        input logic [3:0] d,
        input vec_t       a,
        input vec_t       b
    );
        valid_in  = 1'b1;
        cmd       = c;
        selec_v_s = s;
        dest      = d;
        srca      = a;
        srcb      = b;
    endtask

    task automatic single(
        input string      tag,
        input logic [2:0] c,
        input logic       s,
        input logic [3:0] d,
        input vec_t       a,
        input vec_t       b,
        input vec_t       e
    );
        op(c, s, d, a, b);
        step;
        chk({tag, "_we3"}, we3, 1'b1);
        chk({tag, "_ra3"}, ra3, d);
        chk({tag, "_wd3"}, wd3, e);
        chk({tag, "_sel"}, selec_v_s_w, s);
        chk({tag, "_cmd"}, cmd_w, c);
        chk({tag, "_rdy"}, ready, 1'b1);
        valid_in = 1'b0;
    endtask

    vec_t       va;
    vec_t       vi;
    vec_t       ex;
    vec_t       sa;
    int         np;
    logic [3:0] r1;
    logic [3:0] r2;
    vec_t       w1;
    vec_t       w2;

    initial begin
        rst       = 1'b1;
        valid_in  = 1'b0;
        cmd       = 3'b000;
        selec_v_s = 1'b0;
        dest      = 4'd0;
        srca      = '0;
        srcb      = '0;
        for (int i = 0; i < L; i++) begin
            va[i] = W'(i + 1);
            vi[i] = W'(i);
            ex[i] = W'(i) - 32'd1;
        end
        sa     = splat(32'h55);
        sa[15] = 32'h1234;

        #3;
        chk("rst_ready", ready, 1'b1);
        chk("rst_we3", we3, 1'b0);
        chk("rst_ra3", ra3, 4'd0);
        chk("rst_wd3", wd3, '0);
        chk("rst_sel", selec_v_s_w, 1'b0);
        chk("rst_cmd", cmd_w, 3'd0);
        #9;
        rst = 1'b0;

        single("add_v", 3'b000, 1'b1, 4'd3,
               splat(32'd1), splat(32'd7), splat(32'd8));
        single("sub_s", 3'b001, 1'b0, 4'd9,
               '0, splat(32'd1), top(32'hFFFF_FFFF));
        single("add_wrap", 3'b000, 1'b1, 4'd4,
               vi, splat(32'hFFFF_FFFF), ex);
        single("and_v", 3'b010, 1'b1, 4'd10,
               splat(32'hF00F), splat(32'h0FF3), splat(32'h0003));
        single("or_v", 3'b011, 1'b1, 4'd11,
               splat(32'hF00F), splat(32'h0FF3), splat(32'hFFFF));
        single("xor_v", 3'b100, 1'b1, 4'd12,
               splat(32'hF00F), splat(32'h0FF3), splat(32'hFFFC));
        single("mul_v", 3'b110, 1'b1, 4'd13,
               splat(32'h0001_0001), splat(32'h0001_0003),
               splat(32'h0004_0003));
        single("mov_v", 3'b111, 1'b1, 4'd14,
               splat(32'd1), splat(32'hABCD), splat(32'hABCD));
        single("and_s", 3'b010, 1'b0, 4'd15,
               splat(32'hF00F), splat(32'h0FF3), top(32'h0003));
        single("red_s", 3'b101, 1'b0, 4'd8,
               sa, splat(32'hDEAD), top(32'h1234));
        step;
        chk("idle_we3", we3, 1'b0);

        op(3'b101, 1'b1, 4'd5, va, splat(32'hDEAD));
        step;
        valid_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("red_busy_rdy", ready, 1'b0);
            chk("red_busy_we3", we3, 1'b0);
            step;
        end
        chk("red_we3", we3, 1'b1);
        chk("red_wd3", wd3, top(32'd136));
        chk("red_cmd", cmd_w, 3'b101);
        chk("red_ra3", ra3, 4'd5);
        chk("red_sel", selec_v_s_w, 1'b1);
        chk("red_rdy", ready, 1'b1);
        step;
        chk("red_we3_once", we3, 1'b0);

        op(3'b101, 1'b1, 4'd2, splat(32'h2000_0000), '0);
        step;
        valid_in = 1'b0;
        repeat (3) step;
        chk("wrap_we3", we3, 1'b1);
        chk("wrap_wd3", wd3, top(32'd0));

        op(3'b101, 1'b1, 4'd6, va, '0);
        step;
        valid_in = 1'b0;
        step;
        rst = 1'b1;
        #1;
        chk("abort_rdy", ready, 1'b1);
        chk("abort_we3", we3, 1'b0);
        chk("abort_ra3", ra3, 4'd0);
        #2;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step;
            chk("abort_quiet", we3, 1'b0);
        end
        single("add_after", 3'b000, 1'b1, 4'd1,
               splat(32'd2), splat(32'd3), splat(32'd5));

        op(3'b101, 1'b1, 4'd5, va, '0);
        step;
        cmd  = 3'b111;
        dest = 4'd7;
        srcb = splat(32'hABCD);
        np   = 0;
        r1   = '0;
        r2   = '0;
        w1   = '0;
        w2   = '0;
        for (int i = 1; i <= 8; i++) begin
            step;
            if (we3) begin
                np++;
                if (np == 1) begin
                    r1 = ra3;
                    w1 = wd3;
                end else begin
                    r2 = ra3;
                    w2 = wd3;
                end
            end
            if (i == 4) valid_in = 1'b0;
        end
        chk("q_pulses", np, 32'd2);
        chk("q_first_ra3", r1, 4'd5);
        chk("q_first_wd3", w1, top(32'd136));
        chk("q_second_ra3", r2, 4'd7);
        chk("q_second_wd3", w2, splat(32'hABCD));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
